// File: rtl/ctrl_fsm_ws.sv
// ctrl_fsm_ws: multicycle CPU control FSM with memory wait states.
// Moore machine: datapath and fetch controls are decoded from the registered
// state. The only exception is illegal, which pulses in DEC when the opcode/op
// pair cannot be decoded. IF1, LDR_RD and STR_WR dwell at least MEM_LAT
// cycles and then leave on mem_rdy.

module ctrl_fsm_ws #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [2:0]         opcode,
  input  logic [1:0]         op,
  input  logic               mem_rdy,
  output logic [1:0]         nsel,
  output logic [1:0]         vsel,
  output logic [1:0]         mem_cmd,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic               bsel,
  output logic               shiftsel,
  output logic               write,
  output logic               load_pc,
  output logic               reset_pc,
  output logic               addr_sel,
  output logic               load_ir,
  output logic               load_addr,
  output logic               w,
  output logic               illegal,
  output logic [STATE_W-1:0] state_out
);

  typedef enum logic [4:0] {
    StRst   = 5'd0,
    StIf1   = 5'd1,
    StIf2   = 5'd2,
    StUpc   = 5'd3,
    StDec   = 5'd4,
    StMovi  = 5'd5,
    StMovr  = 5'd6,
    StLda   = 5'd7,
    StLdb   = 5'd8,
    StExec  = 5'd9,
    StWb    = 5'd10,
    StMadr  = 5'd11,
    StMadc  = 5'd12,
    StLdrRd = 5'd13,
    StLdrWb = 5'd14,
    StStrB  = 5'd15,
    StStrWr = 5'd16,
    StHalt  = 5'd17
  } state_e;

  localparam logic [1:0] MemRead  = 2'b00;
  localparam logic [1:0] MemNone  = 2'b01;
  localparam logic [1:0] MemWrite = 2'b10;

  localparam logic [1:0] NselRn = 2'b11;
  localparam logic [1:0] NselRm = 2'b01;
  localparam logic [1:0] NselRd = 2'b10;

  localparam logic [1:0] VselC     = 2'b00;
  localparam logic [1:0] VselImm   = 2'b01;
  localparam logic [1:0] VselMdata = 2'b11;

  localparam logic [3:0] LatMax = 4'(MEM_LAT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // Remembers that the instruction in flight is MOVR, so EXEC keeps asel high.
  logic       movr_q, movr_d;

  logic in_wait;
  logic wait_exit;
  logic dec_movi, dec_movr, dec_alu, dec_ldr, dec_str, dec_halt, dec_legal;

  // Instruction decode and the wait-state exit condition
  always_comb begin
    dec_movi  = (opcode == 3'b110) && (op == 2'b10);
    dec_movr  = (opcode == 3'b110) && (op == 2'b00);
    dec_alu   = (opcode == 3'b101);
    dec_ldr   = (opcode == 3'b011);
    dec_str   = (opcode == 3'b100);
    dec_halt  = (opcode == 3'b111);
    dec_legal = dec_movi | dec_movr | dec_alu | dec_ldr | dec_str | dec_halt;
    in_wait   = (state_q == StIf1) || (state_q == StLdrRd) || (state_q == StStrWr);
    wait_exit = (wait_cnt_q >= LatMax) && mem_rdy;
  end

  // Next-state selection; opcode/op are looked at only in DEC, EXEC and MADC
  always_comb begin
    state_d = state_q;
    movr_d  = movr_q;
    unique case (state_q)
      StRst:   state_d = StIf1;
      StIf1:   if (wait_exit) state_d = StIf2;
      StIf2:   state_d = StUpc;
      StUpc:   state_d = StDec;
      StDec: begin
        movr_d = dec_movr;
        if (dec_movi)                 state_d = StMovi;
        else if (dec_movr)            state_d = StMovr;
        else if (dec_alu)             state_d = StLda;
        else if (dec_ldr || dec_str)  state_d = StMadr;
        else if (dec_halt)            state_d = StHalt;
        else                          state_d = StIf1;
      end
      StMovi:  state_d = StIf1;
      StMovr:  state_d = StExec;
      StLda:   state_d = StLdb;
      StLdb:   state_d = StExec;
      // A compare only updates status, so it skips writeback.
      StExec:  state_d = (op == 2'b01) ? StIf1 : StWb;
      StWb:    state_d = StIf1;
      StMadr:  state_d = StMadc;
      StMadc: begin
        if (dec_ldr)      state_d = StLdrRd;
        else if (dec_str) state_d = StStrB;
        else              state_d = StIf1;
      end
      StLdrRd: if (wait_exit) state_d = StLdrWb;
      StLdrWb: state_d = StIf1;
      StStrB:  state_d = StStrWr;
      StStrWr: if (wait_exit) state_d = StIf1;
      StHalt:  if (s) state_d = StIf1;
      default: state_d = StRst;
    endcase
  end

  // Wait counter restarts on every state change and saturates at MEM_LAT
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 4'd0;
    end else if (in_wait && (wait_cnt_q < LatMax)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StRst;
      wait_cnt_q <= 4'd0;
      movr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      movr_q     <= movr_d;
    end
  end

  // Moore output decode; everything idles at zero with mem_cmd=NONE
  always_comb begin
    nsel      = 2'b00;
    vsel      = VselC;
    mem_cmd   = MemNone;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shiftsel  = 1'b0;
    write     = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    w         = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StRst: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      StIf1: begin
        addr_sel = 1'b1;
        mem_cmd  = MemRead;
        w        = 1'b1;
      end
      StIf2: begin
        addr_sel = 1'b1;
        mem_cmd  = MemRead;
        load_ir  = 1'b1;
      end
      StUpc:   load_pc = 1'b1;
      StDec:   illegal = ~dec_legal;
      StMovi: begin
        nsel  = NselRn;
        vsel  = VselImm;
        write = 1'b1;
      end
      StMovr: begin
        nsel  = NselRm;
        loadb = 1'b1;
        asel  = 1'b1;
      end
      StLda: begin
        nsel  = NselRn;
        loada = 1'b1;
      end
      StLdb: begin
        nsel  = NselRm;
        loadb = 1'b1;
      end
      StExec: begin
        loadc = 1'b1;
        loads = 1'b1;
        asel  = movr_q;
      end
      StWb: begin
        nsel  = NselRd;
        vsel  = VselC;
        write = 1'b1;
      end
      StMadr: begin
        nsel  = NselRn;
        loada = 1'b1;
      end
      StMadc: begin
        bsel      = 1'b1;
        shiftsel  = 1'b1;
        loadc     = 1'b1;
        load_addr = 1'b1;
      end
      StLdrRd: mem_cmd = MemRead;
      StLdrWb: begin
        mem_cmd = MemRead;
        nsel    = NselRd;
        vsel    = VselMdata;
        write   = 1'b1;
      end
      StStrB: begin
        nsel  = NselRd;
        loadb = 1'b1;
        asel  = 1'b1;
        loadc = 1'b1;
      end
      StStrWr: mem_cmd = MemWrite;
      StHalt:  ;
      default: ;
    endcase
  end

  assign state_out = STATE_W'(state_q);

endmodule

// File: tb/tb_ctrl_fsm_ws.sv
// Bench for ctrl_fsm_ws: three instances (MEM_LAT = 0, 1, 2) share stimulus.
// A route-queue model predicts state and outputs every cycle; directed
// segments add hand-computed literal expectations.

module tb_ctrl_fsm_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, s, mem_rdy;
  logic [2:0] opcode;
  logic [1:0] op;

  logic [1:0] nsel [3];
  logic [1:0] vsel [3];
  logic [1:0] mem_cmd [3];
  logic       loada [3], loadb [3], loadc [3], loads [3], asel [3], bsel [3];
  logic       shiftsel [3], write [3], load_pc [3], reset_pc [3], addr_sel [3];
  logic       load_ir [3], load_addr [3], w [3], illegal [3];
  logic [4:0] state_out [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ctrl_fsm_ws #(.MEM_LAT(g), .STATE_W(5)) u_dut (
      .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op), .mem_rdy(mem_rdy),
      .nsel(nsel[g]), .vsel(vsel[g]), .mem_cmd(mem_cmd[g]),
      .loada(loada[g]), .loadb(loadb[g]), .loadc(loadc[g]), .loads(loads[g]),
      .asel(asel[g]), .bsel(bsel[g]), .shiftsel(shiftsel[g]), .write(write[g]),
      .load_pc(load_pc[g]), .reset_pc(reset_pc[g]), .addr_sel(addr_sel[g]),
      .load_ir(load_ir[g]), .load_addr(load_addr[g]), .w(w[g]), .illegal(illegal[g]),
      .state_out(state_out[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current state, cycles spent in it, and the queue of states still to visit.
  int m_st [3];
  int m_dwell [3];
  int m_rt [3][8];
  int m_len [3];
  int m_head [3];
  bit m_movr [3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_legal(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b110 && (o == 2'b10 || o == 2'b00)) || oc == 3'b101 ||
           oc == 3'b011 || oc == 3'b100 || oc == 3'b111;
  endfunction

  task automatic push_rt(input int k, input int v);
    m_rt[k][m_len[k]] = v;
    m_len[k]++;
  endtask

  task automatic model_step(input int k);
    bit blocked;
    int nxt;
    if (!reset) begin
      m_st[k] = 0; m_dwell[k] = 0; m_len[k] = 0; m_head[k] = 0; m_movr[k] = 0;
    end else begin
      blocked = 0;
      if (m_st[k] == 1 || m_st[k] == 13 || m_st[k] == 16) blocked = !(m_dwell[k] >= k && mem_rdy);
      else if (m_st[k] == 17) blocked = !s;
      if (blocked) begin
        m_dwell[k]++;
      end else begin
        if (m_st[k] == 4) begin
          m_len[k] = 0; m_head[k] = 0; m_movr[k] = 0;
          if (opcode == 3'b110 && op == 2'b10) push_rt(k, 5);
          else if (opcode == 3'b110 && op == 2'b00) begin
            m_movr[k] = 1; push_rt(k, 6); push_rt(k, 9); push_rt(k, 10);
          end else if (opcode == 3'b101) begin
            push_rt(k, 7); push_rt(k, 8); push_rt(k, 9);
            if (op != 2'b01) push_rt(k, 10);
          end else if (opcode == 3'b011) begin
            push_rt(k, 11); push_rt(k, 12); push_rt(k, 13); push_rt(k, 14);
          end else if (opcode == 3'b100) begin
            push_rt(k, 11); push_rt(k, 12); push_rt(k, 15); push_rt(k, 16);
          end else if (opcode == 3'b111) push_rt(k, 17);
        end
        if (m_head[k] < m_len[k]) begin
          nxt = m_rt[k][m_head[k]];
          m_head[k]++;
        end else nxt = 1;
        if (nxt == 1) begin
          m_len[k] = 0; m_head[k] = 0;
          push_rt(k, 2); push_rt(k, 3); push_rt(k, 4);
        end
        m_st[k] = nxt;
        m_dwell[k] = 0;
      end
    end
  endtask

  // Packed as {nsel, vsel, mem_cmd, loada, loadb, loadc, loads, asel, bsel, shiftsel,
  //            write, load_pc, reset_pc, addr_sel, load_ir, load_addr, w, illegal}
  function automatic logic [20:0] exp_bits(input int st, input bit movr, input bit ill);
    logic [1:0] ns, vs, mc;
    logic la, lb, lc, ls, as, bs, ss, wr, lp, rp, ad, li, lad, ww, il;
    ns = 0; vs = 0; mc = 2'b01;
    {la, lb, lc, ls, as, bs, ss, wr, lp, rp, ad, li, lad, ww, il} = '0;
    case (st)
      0:  begin rp = 1; lp = 1; end
      1:  begin ad = 1; mc = 2'b00; ww = 1; end
      2:  begin ad = 1; mc = 2'b00; li = 1; end
      3:  lp = 1;
      4:  il = ill;
      5:  begin ns = 2'b11; vs = 2'b01; wr = 1; end
      6:  begin ns = 2'b01; lb = 1; as = 1; end
      7:  begin ns = 2'b11; la = 1; end
      8:  begin ns = 2'b01; lb = 1; end
      9:  begin lc = 1; ls = 1; as = movr; end
      10: begin ns = 2'b10; vs = 2'b00; wr = 1; end
      11: begin ns = 2'b11; la = 1; end
      12: begin bs = 1; ss = 1; lc = 1; lad = 1; end
      13: mc = 2'b00;
      14: begin mc = 2'b00; ns = 2'b10; vs = 2'b11; wr = 1; end
      15: begin ns = 2'b10; lb = 1; as = 1; lc = 1; end
      16: mc = 2'b10;
      default: ;
    endcase
    return {ns, vs, mc, la, lb, lc, ls, as, bs, ss, wr, lp, rp, ad, li, lad, ww, il};
  endfunction

  function automatic logic [20:0] dut_bits(input int k);
    return {nsel[k], vsel[k], mem_cmd[k], loada[k], loadb[k], loadc[k], loads[k], asel[k],
            bsel[k], shiftsel[k], write[k], load_pc[k], reset_pc[k], addr_sel[k],
            load_ir[k], load_addr[k], w[k], illegal[k]};
  endfunction

  // One clock: advance the model with the inputs the DUTs saw, then compare at negedge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d state", k), int'(state_out[k]), m_st[k]);
      check($sformatf("u%0d outputs", k), int'(dut_bits(k)),
            int'(exp_bits(m_st[k], m_movr[k], m_st[k] == 4 && !is_legal(opcode, op))));
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  int exp_seq [10] = '{0, 1, 2, 3, 4, 7, 8, 9, 10, 1};
  int seq [10];
  logic [2:0] g_oc [8] = '{3'b110, 3'b101, 3'b110, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
  logic [1:0] g_op [8] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
  int g_per [8] = '{5, 7, 7, 8, 8, 8, 4, 4};

  initial begin
    int cnt, wr_cnt, wr_idx, dwell, per;
    bit found;
    reset = 1'b0; s = 1'b0; opcode = 3'b101; op = 2'b00; mem_rdy = 1'b1;

    // ALU instruction after a 3-cycle reset
    repeat (3) tick();
    seq[0] = int'(state_out[0]);
    check("rst state_out", int'(state_out[1]), 0);
    check("rst reset_pc", int'(reset_pc[1]), 1);
    check("rst load_pc", int'(load_pc[1]), 1);
    check("rst mem_cmd", int'(mem_cmd[1]), 1);
    check("rst nsel", int'(nsel[1]), 0);
    check("rst w", int'(w[1]), 0);
    reset = 1'b1;
    wr_cnt = 0; wr_idx = -1;
    for (int i = 1; i < 10; i++) begin
      tick();
      seq[i] = int'(state_out[0]);
      if (write[0]) begin wr_cnt++; wr_idx = i; end
    end
    for (int i = 0; i < 10; i++) check($sformatf("alu seq[%0d]", i), seq[i], exp_seq[i]);
    check("alu write count", wr_cnt, 1);
    check("alu write index", wr_idx, 8);

    // IF1 dwell with MEM_LAT=2
    reset_pulse();
    cnt = 0;
    repeat (5) begin
      tick();
      if (state_out[2] == 5'd1 && w[2] && mem_cmd[2] == 2'b00) cnt++;
    end
    check("if1 dwell lat2", cnt, 3);
    check("lat2 after dwell", int'(state_out[2]), 3);

    // LDR with memory stall on MEM_LAT=1
    opcode = 3'b011; op = 2'b00;
    reset_pulse();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state_out[1] == 5'd13) begin found = 1; break; end
    end
    check("ldr reach", int'(found), 1);
    mem_rdy = 1'b0;
    dwell = 1;
    repeat (4) begin
      tick();
      if (state_out[1] == 5'd13) dwell++;
    end
    mem_rdy = 1'b1;
    tick();
    check("ldr_rd dwell", dwell, 5);
    check("ldr_wb state", int'(state_out[1]), 14);
    check("ldr_wb write", int'(write[1]), 1);
    check("ldr_wb vsel", int'(vsel[1]), 3);
    check("ldr_wb nsel", int'(nsel[1]), 2);
    tick();
    check("after ldr_wb", int'(state_out[1]), 1);

    // Illegal opcode
    opcode = 3'b010;
    reset_pulse();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (illegal[1]) begin found = 1; break; end
    end
    check("illegal seen", int'(found), 1);
    check("illegal in dec", int'(state_out[1]), 4);
    tick();
    check("illegal next state", int'(state_out[1]), 1);
    check("illegal one cycle", int'(illegal[1]), 0);

    // HALT then resume
    opcode = 3'b111;
    reset_pulse();
    repeat (25) tick();
    for (int k = 0; k < 3; k++) check($sformatf("u%0d halted", k), int'(state_out[k]), 17);
    s = 1'b1;
    tick();
    s = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("u%0d resume", k), int'(state_out[k]), 1);

    // Reset in the middle of a store wait
    opcode = 3'b100;
    reset_pulse();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (state_out[1] == 5'd16) begin found = 1; break; end
    end
    check("str_wr reach", int'(found), 1);
    mem_rdy = 1'b0;
    repeat (2) tick();
    check("str_wr hold", int'(state_out[1]), 16);
    check("str_wr mem_cmd", int'(mem_cmd[1]), 2);
    reset = 1'b0;
    tick();
    check("str reset state", int'(state_out[1]), 0);
    check("str reset mem_cmd", int'(mem_cmd[1]), 1);
    reset = 1'b1;
    mem_rdy = 1'b1;

    // Instruction periods with MEM_LAT=0
    for (int j = 0; j < 8; j++) begin
      opcode = g_oc[j]; op = g_op[j];
      reset_pulse();
      found = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (state_out[0] == 5'd1) begin found = 1; break; end
      end
      per = 0;
      if (found) begin
        found = 0;
        for (int i = 0; i < 20; i++) begin
          tick();
          per++;
          if (state_out[0] == 5'd1) begin found = 1; break; end
        end
      end
      if (!found) per = -1;
      check($sformatf("period oc=%b op=%b", g_oc[j], g_op[j]), per, g_per[j]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_ws.md
CTRL_FSM_WS -- requirements
Module: ctrl_fsm_ws

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning minimum wait cycles in each memory-access state before mem_rdy is honoured (legal 0..15).
REQ-002 SHALL have parameter STATE_W, default 5, meaning width of state_out (>=5).
REQ-003 SHALL have ports:
  - clk  in  1  rising-edge clock
  - reset  in  1  synchronous, active-low reset
  - s  in  1  resume pulse from HALT
  - opcode  in  3  instruction opcode
  - op  in  2  instruction sub-op
  - mem_rdy  in  1  memory handshake ready
  - nsel  out  2  regfile select: 11=Rn, 01=Rm, 10=Rd
  - vsel  out  2  writeback source: 00=C, 01=imm, 11=mdata
  - mem_cmd  out  2  00=READ, 01=NONE, 10=WRITE
  - loada, loadb, loadc, loads, asel, bsel, shiftsel, write  out  1 each  datapath controls
  - load_pc, reset_pc, addr_sel, load_ir, load_addr  out  1 each  fetch/address controls
  - w  out  1  waiting for instruction
  - illegal  out  1  one-cycle pulse on undecodable instruction
  - state_out  out  STATE_W  current state code

Function
REQ-004 SHALL be Moore: all outputs decoded combinationally from registered state (and wait counter for none); every output not listed for a state SHALL be 0, except mem_cmd=NONE; no output SHALL hold a value from a previous state.
REQ-005 SHALL use states/codes: RST=0, IF1=1, IF2=2, UPC=3, DEC=4, MOVI=5, MOVR=6, LDA=7, LDB=8, EXEC=9, WB=10, MADR=11, MADC=12, LDR_RD=13, LDR_WB=14, STR_B=15, STR_WR=16, HALT=17.
REQ-006 Transitions: RST->IF1; IF1->IF2 on wait-exit; IF2->UPC; UPC->DEC.
REQ-007 DEC: opcode 110 & op 10 ->MOVI; 110 & op 00 ->MOVR; 101 ->LDA; 011 or 100 ->MADR; 111 ->HALT; any other ->IF1 with illegal=1 that cycle.
REQ-008 MOVI->IF1; MOVR->EXEC; LDA->LDB->EXEC; EXEC->IF1 if op==01 (compare), else WB; WB->IF1.
REQ-009 MADR->MADC; MADC->LDR_RD if opcode 011, ->STR_B if 100; LDR_RD->LDR_WB on wait-exit; LDR_WB->IF1; STR_B->STR_WR; STR_WR->IF1 on wait-exit.
REQ-010 HALT: stay while s=0; s=1 ->IF1 next cycle.
REQ-011 Wait counter (4 bits): cleared on every transition into IF1/LDR_RD/STR_WR; increments saturating at MEM_LAT while in that state; wait-exit = (counter>=MEM_LAT) & mem_rdy; MEM_LAT=0 allows exit in first cycle.
REQ-012 Outputs: RST: reset_pc=1, load_pc=1. IF1: addr_sel=1, mem_cmd=READ, w=1. IF2: addr_sel=1, mem_cmd=READ, load_ir=1. UPC: load_pc=1. DEC: none.
REQ-013 Outputs: MOVI: nsel=11, vsel=01, write=1. MOVR: nsel=01, loadb=1, asel=1. LDA: nsel=11, loada=1. LDB: nsel=01, loadb=1. EXEC: loadc=1, loads=1 (MOVR path also, asel=1). WB: nsel=10, vsel=00, write=1.
REQ-014 Outputs: MADR: nsel=11, loada=1. MADC: bsel=1, shiftsel=1, loadc=1, load_addr=1. LDR_RD: mem_cmd=READ. LDR_WB: mem_cmd=READ, nsel=10, vsel=11, write=1. STR_B: nsel=10, loadb=1, asel=1, loadc=1. STR_WR: mem_cmd=WRITE.
REQ-015 mem_cmd SHALL remain constant for the whole dwell in a wait state; mem_rdy outside wait states SHALL be ignored.
REQ-016 Latency with MEM_LAT=0, mem_rdy=1: ALU op 8 cycles IF1..WB; compare 7; MOVI 5; LDR 8; STR 8.
REQ-017 opcode/op SHALL be sampled only in DEC, EXEC and MADC.

Reset
REQ-018 reset=0 at a rising edge SHALL put state in RST and clear the wait counter, from any state including mid-wait and HALT; an in-flight memory command SHALL be dropped (mem_cmd=NONE in RST).
REQ-019 While in RST, state_out=0, reset_pc=1, load_pc=1, all other 1-bit outputs 0, nsel=00, vsel=00; first cycle after reset released SHALL be IF1.

Verification
REQ-020 Reset held 3 cycles then released, opcode=101 op=00, mem_rdy=1, MEM_LAT=0 -> state_out sequence 0,1,2,3,4,7,8,9,10,1; write=1 only in WB.
REQ-021 MEM_LAT=2, mem_rdy=1 from start -> IF1 dwells exactly 3 cycles with mem_cmd=READ, w=1 throughout.
REQ-022 LDR (opcode 011), MEM_LAT=1, mem_rdy low 4 cycles in LDR_RD then high -> LDR_RD lasts 5 cycles; LDR_WB asserts write=1, vsel=11, nsel=10 for one cycle.
REQ-023 opcode=010 at DEC -> illegal=1 for exactly one cycle, next state IF1, no write/load asserted.
REQ-024 opcode=111 -> HALT held 10 cycles with s=0; s=1 one cycle -> IF1 next; reset=0 during STR_WR -> RST next cycle, mem_cmd=NONE.
